// File: rtl/bist_banco_registros_pkg.sv
// Shared types and expected-pattern function for the register file BIST.
// Optional build macro BIST_X0_ZERO_EN: register 0 is hardwired to zero.
package banco_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  // Working width of expected(); callers cast down to their own register width,
  // so register files wider than this are not supported.
  localparam int EXP_W = 256;

  // E(ptr): base pattern (inverted on the second pass) XOR the zero-extended pointer.
  function automatic logic [EXP_W-1:0] expected(
    input logic [EXP_W-1:0] ptr,
    input logic             pass,
    input logic [EXP_W-1:0] pattern
  );
`ifdef BIST_X0_ZERO_EN
    if (ptr == '0) return '0;
`endif
    return (pass ? ~pattern : pattern) ^ ptr;
  endfunction

endpackage

// File: rtl/bist_banco_registros_if.sv
// Register file port bundle between the BIST controller (master) and BancoRegistros (slave).
interface bist_banco_registros_if #(
  parameter int N    = 32,
  parameter int Bits = 64
);

  logic                 wr_en;
  logic [$clog2(N)-1:0] ptr_wr;
  logic [Bits-1:0]      data_wr;
  logic [$clog2(N)-1:0] ptr_rd_1;
  logic [$clog2(N)-1:0] ptr_rd_2;
  logic [Bits-1:0]      data_rd_1;
  logic [Bits-1:0]      data_rd_2;

  modport master (
    output wr_en, ptr_wr, data_wr, ptr_rd_1, ptr_rd_2,
    input  data_rd_1, data_rd_2
  );

  modport slave (
    input  wr_en, ptr_wr, data_wr, ptr_rd_1, ptr_rd_2,
    output data_rd_1, data_rd_2
  );

endinterface

// File: rtl/bist_banco_registros_comparador.sv
// One read-port checker: regenerates E(ptr) for the pass and flags a data mismatch.
module bist_comparador
  import banco_bist_pkg::*;
#(
  parameter int              Bits    = 64,
  parameter int              PTR_W   = 5,
  parameter logic [Bits-1:0] PATTERN = {Bits/8{8'hA5}}
) (
  input  logic [PTR_W-1:0] ptr,
  input  logic             pass,
  input  logic [Bits-1:0]  data,
  output logic             mismatch
);

  logic [Bits-1:0] exp_val;

  assign exp_val  = Bits'(expected(EXP_W'(ptr), pass, EXP_W'(PATTERN)));
  assign mismatch = (data != exp_val);

endmodule

// File: rtl/bist_banco_registros.sv
// March-style BIST for BancoRegistros: write E(a) to all registers, read back in pairs,
// repeat with the inverted pattern; report pass/fail, error count and first failing pointer.
module bist_banco_registros
  import banco_bist_pkg::*;
#(
  parameter int              N       = 32,
  parameter int              Bits    = 64,
  parameter logic [Bits-1:0] PATTERN = {Bits/8{8'hA5}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  bist_banco_registros_if.master rf,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [$clog2(N)+1:0]   err_count,
  output logic [$clog2(N)-1:0]   first_err_ptr
);

  localparam int PW = $clog2(N);
  localparam int EW = PW + 2;

  function automatic logic [EW-1:0] sat_add(input logic [EW-1:0] a, input logic [1:0] inc);
    logic [EW:0] s;
    s = {1'b0, a} + {{(EW-1){1'b0}}, inc};
    return s[EW] ? '1 : s[EW-1:0];
  endfunction

  bist_state_t     state_q, state_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic            pass_q, pass_d;

  logic            wr_en_q, wr_en_d;
  logic [PW-1:0]   ptr_wr_q, ptr_wr_d;
  logic [Bits-1:0] data_wr_q, data_wr_d;
  logic [PW-1:0]   ptr_rd_1_q, ptr_rd_1_d;
  logic [PW-1:0]   ptr_rd_2_q, ptr_rd_2_d;
  logic            vld_p1, vld_p1_d;
  logic            pass_p1, pass_p1_d;

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            fail_q, fail_d;
  logic [EW-1:0]   err_q, err_d;
  logic [PW-1:0]   first_q, first_d;

  logic            mis_1, mis_2;
  logic [Bits-1:0] exp_wr;

  assign exp_wr = Bits'(expected(EXP_W'(cnt_q), pass_q, EXP_W'(PATTERN)));

  bist_comparador #(.Bits(Bits), .PTR_W(PW), .PATTERN(PATTERN)) u_cmp_1 (
    .ptr      (ptr_rd_1_q),
    .pass     (pass_p1),
    .data     (rf.data_rd_1),
    .mismatch (mis_1)
  );

  bist_comparador #(.Bits(Bits), .PTR_W(PW), .PATTERN(PATTERN)) u_cmp_2 (
    .ptr      (ptr_rd_2_q),
    .pass     (pass_p1),
    .data     (rf.data_rd_2),
    .mismatch (mis_2)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    wr_en_d    = 1'b0;
    ptr_wr_d   = ptr_wr_q;
    data_wr_d  = data_wr_q;
    ptr_rd_1_d = ptr_rd_1_q;
    ptr_rd_2_d = ptr_rd_2_q;
    vld_p1_d   = 1'b0;
    pass_p1_d  = pass_q;
    busy_d     = busy_q;
    done_d     = done_q;
    fail_d     = fail_q;
    err_d      = err_q;
    first_d    = first_q;

    // Compare stage: pointers registered last edge, read data valid this cycle.
    if (vld_p1) begin
      err_d = sat_add(err_q, {1'b0, mis_1} + {1'b0, mis_2});
      // err_q still zero means no mismatch has been recorded in this run yet.
      if (err_q == '0 && (mis_1 || mis_2)) first_d = mis_2 ? ptr_rd_2_q : ptr_rd_1_q;
    end

    // Control stage: sequencing and next values of the registered port outputs.
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          fail_d = (err_d != '0);
        end
        if (start && !busy_q) begin
          state_d = WRITE;
          cnt_d   = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          err_d   = '0;
          first_d = '0;
        end
      end
      WRITE: begin
        wr_en_d   = 1'b1;
        ptr_wr_d  = cnt_q;
        data_wr_d = exp_wr;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == PW'(N - 1)) begin
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        vld_p1_d   = 1'b1;
        ptr_rd_1_d = {cnt_q[PW-2:0], 1'b1};
        ptr_rd_2_d = {cnt_q[PW-2:0], 1'b0};
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == PW'(N / 2 - 1)) begin
          cnt_d = '0;
          if (!pass_q) begin
            pass_d  = 1'b1;
            state_d = WRITE;
          end else begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pass_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      ptr_wr_q   <= '0;
      data_wr_q  <= '0;
      ptr_rd_1_q <= '0;
      ptr_rd_2_q <= '0;
      vld_p1     <= 1'b0;
      pass_p1    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      err_q      <= '0;
      first_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
      wr_en_q    <= wr_en_d;
      ptr_wr_q   <= ptr_wr_d;
      data_wr_q  <= data_wr_d;
      ptr_rd_1_q <= ptr_rd_1_d;
      ptr_rd_2_q <= ptr_rd_2_d;
      vld_p1     <= vld_p1_d;
      pass_p1    <= pass_p1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      err_q      <= err_d;
      first_q    <= first_d;
    end
  end

  assign rf.wr_en       = wr_en_q;
  assign rf.ptr_wr      = ptr_wr_q;
  assign rf.data_wr     = data_wr_q;
  assign rf.ptr_rd_1    = ptr_rd_1_q;
  assign rf.ptr_rd_2    = ptr_rd_2_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign fail           = fail_q;
  assign err_count      = err_q;
  assign first_err_ptr  = first_q;

endmodule

// File: tb/tb_bist_banco_registros.sv
// Bench for bist_banco_registros: behavioural register file with fault injection,
// table-driven runs, randomized faults against a reference model, reset corner cases.
module tb_bist_banco_registros;

  localparam int N    = 32;
  localparam int Bits = 64;
  localparam int PW   = $clog2(N);
  localparam logic [63:0] PAT = 64'hA5A5A5A5A5A5A5A5;
`ifdef BIST_X0_ZERO_EN
  localparam bit X0 = 1'b1;
`else
  localparam bit X0 = 1'b0;
`endif

  typedef struct packed {
    int          reg_a;
    int          reg_b;
    logic [63:0] or_m;
    logic [63:0] xor_m;
    logic [1:0]  pass_m;
    bit          zero_all;
  } fault_t;

  typedef struct {
    string  name;
    fault_t f;
    bit     extra_start;
    int     exp_err;
    bit     exp_fail;
    int     exp_first;
  } vec_t;

  logic clk, rst, start;
  logic busy, done, fail;
  logic [PW+1:0] err_count;
  logic [PW-1:0] first_err_ptr;

  int checks = 0;
  int errors = 0;

  bist_banco_registros_if #(.N(N), .Bits(Bits)) rf_if ();

  bist_banco_registros #(.N(N), .Bits(Bits)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .rf            (rf_if),
    .busy          (busy),
    .done          (done),
    .fail          (fail),
    .err_count     (err_count),
    .first_err_ptr (first_err_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected register contents for a pointer and pass.
  function automatic logic [63:0] model_e(input int p, input bit ps);
    if (X0 && p == 0) return 64'd0;
    return (ps ? ~PAT : PAT) ^ 64'(p);
  endfunction

  function automatic logic [63:0] apply_fault(input int p, input logic [63:0] v, input bit ps, input fault_t f);
    logic [63:0] r;
    if (f.zero_all) return 64'd0;
    r = v;
    if (p == f.reg_a || p == f.reg_b) begin
      r = r | f.or_m;
      if (f.pass_m[ps]) r = r ^ f.xor_m;
    end
    return r;
  endfunction

  // Behavioural register file plus write-beat monitor.
  logic [63:0] regs [N];
  fault_t flt;
  int wr_beats = 0;
  int beat_base = 0;
  int wr_bad = 0;
  bit cur_pass;
  logic [63:0] rd_base_1, rd_base_2;

  assign cur_pass  = (wr_beats - beat_base) > N;
  assign rd_base_1 = (X0 && rf_if.ptr_rd_1 == '0) ? 64'd0 : regs[rf_if.ptr_rd_1];
  assign rd_base_2 = (X0 && rf_if.ptr_rd_2 == '0) ? 64'd0 : regs[rf_if.ptr_rd_2];
  assign rf_if.data_rd_1 = apply_fault(int'(rf_if.ptr_rd_1), rd_base_1, cur_pass, flt);
  assign rf_if.data_rd_2 = apply_fault(int'(rf_if.ptr_rd_2), rd_base_2, cur_pass, flt);

  always @(posedge clk) begin
    if (rf_if.wr_en) begin
      regs[rf_if.ptr_wr] <= rf_if.data_wr;
      wr_beats <= wr_beats + 1;
      if (int'(rf_if.ptr_wr) != (wr_beats - beat_base) % N ||
          rf_if.data_wr !== model_e((wr_beats - beat_base) % N, (wr_beats - beat_base) >= N))
        wr_bad <= wr_bad + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: walk passes and pairs in test order, counting mismatches.
  task automatic predict(input fault_t f, output int errs, output int first);
    int emax;
    bit found;
    emax  = (1 << (PW + 2)) - 1;
    errs  = 0;
    first = 0;
    found = 0;
    for (int ps = 0; ps < 2; ps++)
      for (int i = 0; i < N / 2; i++)
        for (int k = 0; k < 2; k++) begin
          int p;
          p = 2 * i + k;
          if (apply_fault(p, model_e(p, ps[0]), ps[0], f) !== model_e(p, ps[0])) begin
            if (errs < emax) errs++;
            if (!found) begin
              first = p;
              found = 1;
            end
          end
        end
  endtask

  task automatic run_case(input string nm, input fault_t f, input bit extra,
                          input int exp_err, input bit exp_fail, input int exp_first);
    int cyc;
    int bad0;
    flt = f;
    @(posedge clk);
    #1;
    beat_base = wr_beats;
    bad0 = wr_bad;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, "_busy_start"}, 64'(busy), 64'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (extra && cyc == 40);
    end
    start = 1'b0;
    chk({nm, "_done_cycle"}, 64'(cyc), 64'd97);
    chk({nm, "_err_count"}, 64'(err_count), 64'(exp_err));
    chk({nm, "_fail"}, 64'(fail), 64'(exp_fail));
    chk({nm, "_first_err_ptr"}, 64'(first_err_ptr), 64'(exp_first));
    chk({nm, "_busy_end"}, 64'(busy), 64'd0);
    chk({nm, "_write_beats"}, 64'(wr_beats - beat_base), 64'(2 * N));
    chk({nm, "_write_data"}, 64'(wr_bad - bad0), 64'd0);
  endtask

  fault_t none_f;
  vec_t   tbl[5];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    none_f = '{reg_a: -1, reg_b: -1, or_m: 64'd0, xor_m: 64'd0, pass_m: 2'b00, zero_all: 1'b0};
    tbl[0] = '{"clean", none_f, 1'b0, 0, 1'b0, 0};
    tbl[1] = '{"stuck5", '{reg_a: 5, reg_b: -1, or_m: 64'd1, xor_m: 64'd0, pass_m: 2'b00, zero_all: 1'b0},
               1'b0, 1, 1'b1, 5};
    tbl[2] = '{"pair32", '{reg_a: 2, reg_b: 3, or_m: 64'd0, xor_m: 64'h100, pass_m: 2'b01, zero_all: 1'b0},
               1'b0, 2, 1'b1, 2};
`ifdef BIST_X0_ZERO_EN
    tbl[3] = '{"zeros", '{reg_a: -1, reg_b: -1, or_m: 64'd0, xor_m: 64'd0, pass_m: 2'b00, zero_all: 1'b1},
               1'b0, 62, 1'b1, 1};
`else
    tbl[3] = '{"zeros", '{reg_a: -1, reg_b: -1, or_m: 64'd0, xor_m: 64'd0, pass_m: 2'b00, zero_all: 1'b1},
               1'b0, 64, 1'b1, 0};
`endif
    tbl[4] = '{"busy_start", none_f, 1'b1, 0, 1'b0, 0};

    flt   = none_f;
    start = 1'b0;
    rst   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_fail", 64'(fail), 64'd0);
    chk("reset_err", 64'(err_count), 64'd0);
    chk("reset_first", 64'(first_err_ptr), 64'd0);
    chk("reset_wr_en", 64'(rf_if.wr_en), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++)
      run_case(tbl[i].name, tbl[i].f, tbl[i].extra_start, tbl[i].exp_err, tbl[i].exp_fail, tbl[i].exp_first);

    for (int r = 0; r < 6; r++) begin
      fault_t f;
      int e, fp;
      f.reg_a    = int'($urandom_range(0, N - 1));
      f.reg_b    = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, N - 1)) : -1;
      f.or_m     = ($urandom_range(0, 1) != 0) ? (64'd1 << $urandom_range(0, 63)) : 64'd0;
      f.xor_m    = {$urandom, $urandom} & {$urandom, $urandom};
      f.pass_m   = 2'($urandom_range(0, 3));
      f.zero_all = 1'b0;
      predict(f, e, fp);
      run_case($sformatf("rand%0d", r), f, 1'b0, e, (e != 0), fp);
    end

    // Reset while writing: wr_en must drop without waiting for a clock edge.
    flt = '{reg_a: -1, reg_b: -1, or_m: 64'd0, xor_m: 64'd0, pass_m: 2'b00, zero_all: 1'b1};
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("wr_en_before_rst", 64'(rf_if.wr_en), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("wr_en_async_rst", 64'(rf_if.wr_en), 64'd0);
    chk("busy_async_rst", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset during READ of the second pass with errors already accumulated.
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (85) @(posedge clk);
    #1;
    chk("err_before_rst", 64'(err_count != '0), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_read_busy", 64'(busy), 64'd0);
    chk("rst_read_done", 64'(done), 64'd0);
    chk("rst_read_fail", 64'(fail), 64'd0);
    chk("rst_read_err", 64'(err_count), 64'd0);
    chk("rst_read_first", 64'(first_err_ptr), 64'd0);
    chk("rst_read_wr_en", 64'(rf_if.wr_en), 64'd0);
    chk("rst_read_ptrs", 64'({rf_if.ptr_rd_1, rf_if.ptr_rd_2, rf_if.ptr_wr}), 64'd0);
    chk("rst_read_data_wr", rf_if.data_wr, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_case("after_rst", none_f, 1'b0, 0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
